// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bundle: control/redirect inputs and PC outputs.
// master drives control; slave is the sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              exc;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus_inc;
  logic [ADDR_W-1:0] epc;
  logic              pc_valid;
  logic              halted;

  modport master (
    output stall, br_taken, br_target,
    output jump, jump_target,
    output exc, halt, resume,
    input  pc_out, pc_plus_inc, epc,
    input  pc_valid, halted
  );

  modport slave (
    input  stall, br_taken, br_target,
    input  jump, jump_target,
    input  exc, halt, resume,
    output pc_out, pc_plus_inc, epc,
    output pc_valid, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: exception vector, redirect, stall-buffered
// redirect, halt/resume and sequential increment.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [31:0]       EXC_VEC   = 32'h0000_0080,
  parameter int unsigned       INC       = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] MASK = ~(STEP - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC) & MASK;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc_q;
  logic [ADDR_W-1:0] pend_target;
  logic              pend_valid;
  logic              valid_q;
  logic              halted_q;

  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              do_exc;
  logic              do_halt;
  logic              do_hold;
  logic              do_redir;
  logic              do_pend;

  assign redir     = bus.br_taken | bus.jump;
  assign redir_tgt = (bus.br_taken ? bus.br_target
                                   : bus.jump_target) & MASK;

  // One-hot RUN decisions in falling priority order.
  assign do_exc   = bus.exc;
  assign do_halt  = !bus.exc && bus.halt;
  assign do_hold  = !bus.exc && !bus.halt && bus.stall;
  assign do_redir = !bus.exc && !bus.halt && !bus.stall
                    && redir;
  assign do_pend  = !bus.exc && !bus.halt && !bus.stall
                    && !redir && pend_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      epc_q       <= '0;
      pend_target <= '0;
      pend_valid  <= 1'b0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state   <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          unique case (1'b1)
            do_exc: begin
              pc         <= EXC_PC;
              epc_q      <= pc;
              pend_valid <= 1'b0;
            end
            do_halt: begin
              state    <= HALT;
              halted_q <= 1'b1;
              valid_q  <= 1'b0;
            end
            do_hold: begin
              if (redir) begin
                pend_target <= redir_tgt;
                pend_valid  <= 1'b1;
              end
            end
            do_redir: begin
              pc         <= redir_tgt;
              pend_valid <= 1'b0;
            end
            do_pend: begin
              pc         <= pend_target;
              pend_valid <= 1'b0;
            end
            default: pc <= pc + STEP;
          endcase
        end
        HALT: begin
          if (bus.exc) begin
            pc         <= EXC_PC;
            epc_q      <= pc;
            pend_valid <= 1'b0;
            state      <= RUN;
            valid_q    <= 1'b1;
            halted_q   <= 1'b0;
          end else if (bus.resume) begin
            state    <= RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.pc_out      = pc;
  assign bus.pc_plus_inc = pc + STEP;
  assign bus.epc         = epc_q;
  assign bus.pc_valid    = valid_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: 32-bit and 8-bit instances against
// a behavioural model, directed steps then random traffic.
module tb_pc_sequencer;
  localparam int unsigned W0  = 32;
  localparam int unsigned W1  = 8;
  localparam int unsigned INC = 4;
  localparam logic [31:0] EV  = 32'h80;
  localparam logic [7:0]  RV1 = 8'h20;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b00;
  int checks = 0;
  int failures = 0;

  pc_sequencer_if #(.ADDR_W(W0)) b0 ();
  pc_sequencer_if #(.ADDR_W(W1)) b1 ();

  pc_sequencer #(
    .ADDR_W(W0), .RESET_VEC(32'h0),
    .EXC_VEC(EV), .INC(INC)
  ) u0 (.clk(clk), .reset(rst[0]), .bus(b0.slave));

  pc_sequencer #(
    .ADDR_W(W1), .RESET_VEC(RV1),
    .EXC_VEC(EV), .INC(INC)
  ) u1 (.clk(clk), .reset(rst[1]), .bus(b1.slave));

  always #5 clk = ~clk;

  typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t mode [2];
  longint unsigned mpc [2];
  longint unsigned mepc [2];
  longint unsigned mpt [2];
  bit mpend [2];
  bit mval [2];
  bit mhalt [2];

  bit st, bt, jp, ex, hl, rs;
  longint unsigned bta, jta;

  function automatic longint unsigned wrap(int d, longint unsigned v);
    longint unsigned m;
    m = (d == 0) ? (64'd1 << W0) : (64'd1 << W1);
    return v % m;
  endfunction

  function automatic longint unsigned aln(int d, longint unsigned v);
    return wrap(d, v) / INC * INC;
  endfunction

  task automatic mreset(int d);
    mode[d]  = M_BOOT;
    mpc[d]   = (d == 0) ? 0 : RV1;
    mepc[d]  = 0;
    mpt[d]   = 0;
    mpend[d] = 0;
    mval[d]  = 0;
    mhalt[d] = 0;
  endtask

  task automatic mexc(int d);
    mepc[d]  = mpc[d];
    mpc[d]   = aln(d, EV);
    mpend[d] = 0;
  endtask

  task automatic medge(int d);
    longint unsigned tgt;
    tgt = aln(d, bt ? bta : jta);
    if (!rst[d]) begin
      mreset(d);
      return;
    end
    case (mode[d])
      M_BOOT: begin
        mode[d] = M_RUN;
        mval[d] = 1;
      end
      M_RUN: begin
        if (ex) mexc(d);
        else if (hl) begin
          mode[d] = M_HALT; mhalt[d] = 1; mval[d] = 0;
        end else if (st) begin
          if (bt || jp) begin
            mpt[d] = tgt; mpend[d] = 1;
          end
        end else if (bt || jp) begin
          mpc[d] = tgt; mpend[d] = 0;
        end else if (mpend[d]) begin
          mpc[d] = mpt[d]; mpend[d] = 0;
        end else mpc[d] = wrap(d, mpc[d] + INC);
      end
      default: begin
        if (ex || rs) begin
          if (ex) mexc(d);
          mode[d] = M_RUN; mval[d] = 1; mhalt[d] = 0;
        end
      end
    endcase
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] pc, pi, ep, v, h;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        pc = 64'(b0.pc_out); pi = 64'(b0.pc_plus_inc);
        ep = 64'(b0.epc);
        v = 64'(b0.pc_valid); h = 64'(b0.halted);
      end else begin
        pc = 64'(b1.pc_out); pi = 64'(b1.pc_plus_inc);
        ep = 64'(b1.epc);
        v = 64'(b1.pc_valid); h = 64'(b1.halted);
      end
      chk($sformatf("pc%0d", d), pc, mpc[d]);
      chk($sformatf("pcinc%0d", d), pi, wrap(d, mpc[d] + INC));
      chk($sformatf("epc%0d", d), ep, mepc[d]);
      chk($sformatf("valid%0d", d), v, 64'(mval[d]));
      chk($sformatf("halted%0d", d), h, 64'(mhalt[d]));
    end
  endtask

  task automatic drive();
    b0.stall = st; b1.stall = st;
    b0.br_taken = bt; b1.br_taken = bt;
    b0.jump = jp; b1.jump = jp;
    b0.exc = ex; b1.exc = ex;
    b0.halt = hl; b1.halt = hl;
    b0.resume = rs; b1.resume = rs;
    b0.br_target = bta[31:0]; b1.br_target = bta[7:0];
    b0.jump_target = jta[31:0]; b1.jump_target = jta[7:0];
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    for (int d = 0; d < 2; d++) medge(d);
    #1 check_all();
  endtask

  task automatic async_reset(int d);
    #2 rst[d] = 1'b0;
    mreset(d);
    #1 check_all();
  endtask

  initial begin
    {st, bt, jp, ex, hl, rs} = '0;
    bta = 0; jta = 0;
    for (int d = 0; d < 2; d++) mreset(d);
    drive();
    #12 check_all();
    chk("rst_pc", 64'(b0.pc_out), 64'h0);
    chk("rst_valid", 64'(b0.pc_valid), 64'h0);
    chk("rst_pc8", 64'(b1.pc_out), 64'(RV1));
    rst = 2'b11;

    step();
    chk("t1_boot_pc", 64'(b0.pc_out), 64'h0);
    chk("t1_boot_valid", 64'(b0.pc_valid), 64'h1);
    step(); chk("t1_pc4", 64'(b0.pc_out), 64'h4);
    step(); chk("t1_pc8", 64'(b0.pc_out), 64'h8);
    step(); chk("t1_pcc", 64'(b0.pc_out), 64'hc);
    step(); chk("t2_start", 64'(b0.pc_out), 64'h10);

    st = 1; bt = 1; bta = 'h40;
    step(); chk("t2_hold1", 64'(b0.pc_out), 64'h10);
    bt = 0;
    step(); chk("t2_hold2", 64'(b0.pc_out), 64'h10);
    st = 0;
    step(); chk("t2_pend", 64'(b0.pc_out), 64'h40);
    step(); chk("t2_next", 64'(b0.pc_out), 64'h44);

    bt = 1; bta = 'h100; jp = 1; jta = 'h200;
    step(); chk("t3_brwins", 64'(b0.pc_out), 64'h100);
    jp = 0; bta = 'h103;
    step(); chk("t3_align", 64'(b0.pc_out), 64'h100);

    bt = 0; jp = 1; jta = 'h24;
    step();
    jp = 0; st = 1; bt = 1; bta = 'h60; ex = 1;
    step();
    chk("t4_vec", 64'(b0.pc_out), 64'h80);
    chk("t4_epc", 64'(b0.epc), 64'h24);
    st = 0; bt = 0; ex = 0;
    step(); chk("t4_nopend", 64'(b0.pc_out), 64'h84);

    jp = 1; jta = 'h30;
    step();
    jp = 0; hl = 1;
    step();
    hl = 0;
    chk("t5_halted", 64'(b0.halted), 64'h1);
    chk("t5_invalid", 64'(b0.pc_valid), 64'h0);
    st = 1; bt = 1; bta = 'h90;
    for (int i = 0; i < 5; i++) begin
      step(); chk("t5_hold", 64'(b0.pc_out), 64'h30);
    end
    st = 0; bt = 0; rs = 1;
    step();
    rs = 0;
    chk("t5_resume_valid", 64'(b0.pc_valid), 64'h1);
    chk("t5_resume_pc", 64'(b0.pc_out), 64'h30);
    step(); chk("t5_next", 64'(b0.pc_out), 64'h34);

    jp = 1; jta = 'hfc;
    step();
    jp = 0;
    chk("t6_fc", 64'(b1.pc_out), 64'hfc);
    step(); chk("t6_wrap", 64'(b1.pc_out), 64'h0);
    st = 1; bt = 1; bta = 'h40;
    step();
    async_reset(1);
    chk("t6_rst_now", 64'(b1.pc_out), 64'(RV1));
    st = 0; bt = 0;
    step();
    rst[1] = 1'b1;
    step(); chk("t6_boot", 64'(b1.pc_valid), 64'h1);
    step(); chk("t6_nopend", 64'(b1.pc_out), 64'(RV1) + 4);

    for (int i = 0; i < 400; i++) begin
      st = ($urandom % 4) == 0;
      bt = ($urandom % 5) == 0;
      jp = ($urandom % 6) == 0;
      ex = ($urandom % 25) == 0;
      hl = ($urandom % 20) == 0;
      rs = ($urandom % 4) == 0;
      bta = 64'($urandom);
      jta = 64'($urandom);
      step();
      if (i == 250) begin
        async_reset(0);
        async_reset(1);
        step();
        rst = 2'b11;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
